// File: rtl/mac_operand_feeder.sv
// Operand feeder for the MATRIX MAC: stores vectors A and B, clears the MAC,
// streams A[i]/B[i] pairs, waits for the MAC pipeline, then pulses done.
module mac_operand_feeder #(
    parameter int Nbits   = 4,
    parameter int LEN     = 4,
    parameter int AW      = 2,
    parameter int MAC_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             wr_sel,
    input  logic [AW-1:0]    wr_addr,
    input  logic [Nbits-1:0] wr_data,
    input  logic             start,
    output logic             busy,
    output logic             mac_clr,
    output logic [Nbits-1:0] multiplier,
    output logic [Nbits-1:0] multiplicand,
    output logic             done
);

    localparam int DEPTH = 1 << AW;
    localparam int DW    = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
    localparam logic [AW:0]    LEN_W      = (AW+1)'(LEN);
    localparam logic [AW-1:0]  LAST_IDX   = AW'(LEN - 1);
    localparam logic [DW-1:0]  DRAIN_LAST = DW'(MAC_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

    state_t           state, next_state;
    logic [AW-1:0]    idx, next_idx;
    logic [DW-1:0]    dcnt, next_dcnt;
    logic [Nbits-1:0] a_mem [DEPTH];
    logic [Nbits-1:0] b_mem [DEPTH];
    logic             wr_ok;

    assign wr_ok = wr_en && (state == IDLE) && ({1'b0, wr_addr} < LEN_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                a_mem[i] <= '0;
                b_mem[i] <= '0;
            end
        end else if (wr_ok) begin
            if (wr_sel)
                b_mem[wr_addr] <= wr_data;
            else
                a_mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        next_state = state;
        next_idx   = idx;
        next_dcnt  = dcnt;
        case (state)
            IDLE: begin
                if (start)
                    next_state = CLEAR;
            end
            CLEAR: begin
                next_state = FEED;
                next_idx   = '0;
            end
            FEED: begin
                if (idx == LAST_IDX) begin
                    next_state = DRAIN;
                    next_idx   = '0;
                    next_dcnt  = '0;
                end else begin
                    next_idx = idx + 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt == DRAIN_LAST)
                    next_state = DONE;
                else
                    next_dcnt = dcnt + 1'b1;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                next_idx   = '0;
                next_dcnt  = '0;
            end
        endcase
    end

    // Outputs are registered from the next state/index so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            idx          <= '0;
            dcnt         <= '0;
            busy         <= 1'b0;
            mac_clr      <= 1'b0;
            done         <= 1'b0;
            multiplier   <= '0;
            multiplicand <= '0;
        end else begin
            state        <= next_state;
            idx          <= next_idx;
            dcnt         <= next_dcnt;
            busy         <= (next_state != IDLE);
            mac_clr      <= (next_state == CLEAR);
            done         <= (next_state == DONE);
            multiplier   <= (next_state == FEED) ? a_mem[next_idx] : '0;
            multiplicand <= (next_state == FEED) ? b_mem[next_idx] : '0;
        end
    end

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Self-checking bench for mac_operand_feeder with a behavioural MAC downstream
// and a scoreboard of expected dot products.
module tb_mac_operand_feeder;

    localparam int NB      = 4;
    localparam int LEN     = 4;
    localparam int AW      = 3;
    localparam int MAC_LAT = 1;

    typedef int vec_t [LEN];

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [NB-1:0] wr_data;
    logic          start;
    logic          busy;
    logic          mac_clr;
    logic [NB-1:0] multiplier;
    logic [NB-1:0] multiplicand;
    logic          done;
    logic [7:0]    acc;

    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    int   runs = 0;
    int   exp_q[$];
    vec_t ma;
    vec_t mb;

    mac_operand_feeder #(
        .Nbits(NB), .LEN(LEN), .AW(AW), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_sel(wr_sel),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .start(start),
        .busy(busy),
        .mac_clr(mac_clr),
        .multiplier(multiplier),
        .multiplicand(multiplicand),
        .done(done)
    );

    always #5 clk = ~clk;

    // Downstream MAC with one clock of latency, wrapping at 8 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            acc <= '0;
        else if (mac_clr)
            acc <= '0;
        else
            acc <= acc + 8'(multiplier) * 8'(multiplicand);
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && done) begin
            done_count++;
            if (exp_q.size() == 0)
                checkOutput("unexpected_done", 1, 0);
            else
                checkOutput("dot_product", int'(acc), exp_q.pop_front());
        end
    end

    function automatic int expectedDot();
        int sum = 0;
        for (int i = 0; i < LEN; i++)
            sum += ma[i] * mb[i];
        return sum % 256;
    endfunction

    task automatic writeElement(input logic sel, input int addr, input int data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(addr);
        wr_data = NB'(data);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic loadVectors(input vec_t a, input vec_t b);
        for (int i = 0; i < LEN; i++) begin
            writeElement(1'b0, i, a[i]);
            writeElement(1'b1, i, b[i]);
            ma[i] = a[i];
            mb[i] = b[i];
        end
    endtask

    // mode 0: plain run, 1: write A[0]=9 during FEED, 2: start pulse during FEED,
    // 3: write A[0]=5 in the same cycle as start.
    task automatic applyStimulus(input int mode);
        int e;
        @(negedge clk);
        start = 1'b1;
        if (mode == 3) begin
            wr_en   = 1'b1;
            wr_sel  = 1'b0;
            wr_addr = '0;
            wr_data = NB'(5);
            ma[0]   = 5;
        end
        e = expectedDot();
        exp_q.push_back(e);
        runs++;
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        checkOutput("clear_mac_clr", int'(mac_clr), 1);
        checkOutput("clear_busy", int'(busy), 1);
        checkOutput("clear_mult", int'(multiplier), 0);
        for (int i = 0; i < LEN; i++) begin
            @(negedge clk);
            checkOutput($sformatf("feed_a%0d", i), int'(multiplier), ma[i]);
            checkOutput($sformatf("feed_b%0d", i), int'(multiplicand), mb[i]);
            checkOutput("feed_mac_clr", int'(mac_clr), 0);
            if (mode == 1) begin
                wr_en   = (i == 0);
                wr_sel  = 1'b0;
                wr_addr = '0;
                wr_data = NB'(9);
            end
            if (mode == 2)
                start = (i == 0);
        end
        wr_en = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("drain_mult", int'(multiplier), 0);
        checkOutput("drain_done", int'(done), 0);
        checkOutput("drain_busy", int'(busy), 1);
        @(negedge clk);
        checkOutput("done_pulse", int'(done), 1);
        checkOutput("done_busy", int'(busy), 1);
        @(negedge clk);
        checkOutput("done_low", int'(done), 0);
        checkOutput("idle_busy", int'(busy), 0);
        checkOutput("acc_hold", int'(acc), e);
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end

        repeat (10) @(negedge clk);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_mac_clr", int'(mac_clr), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_mult", int'(multiplier), 0);
        checkOutput("rst_mcand", int'(multiplicand), 0);
        reset = 1'b0;

        repeat (20) @(negedge clk);
        checkOutput("idle_busy20", int'(busy), 0);
        checkOutput("idle_mult20", int'(multiplier), 0);
        checkOutput("idle_acc20", int'(acc), 0);

        $display("[TB] basic dot product");
        loadVectors('{1, 2, 3, 4}, '{1, 1, 1, 1});
        applyStimulus(0);

        $display("[TB] overflow wrap and clear between runs");
        loadVectors('{15, 15, 15, 15}, '{15, 15, 15, 15});
        applyStimulus(0);
        loadVectors('{2, 2, 2, 2}, '{2, 2, 2, 2});
        applyStimulus(0);

        $display("[TB] writes during busy and out of range");
        loadVectors('{1, 2, 3, 4}, '{1, 1, 1, 1});
        applyStimulus(1);
        writeElement(1'b0, 3, 7);
        ma[3] = 7;
        applyStimulus(0);
        writeElement(1'b0, 5, 9);
        writeElement(1'b1, 6, 9);
        applyStimulus(0);

        $display("[TB] same-cycle write and start, start during feed");
        writeElement(1'b0, 3, 4);
        ma[3] = 4;
        applyStimulus(3);
        applyStimulus(2);
        repeat (3) @(negedge clk);
        checkOutput("no_queued_run", int'(busy), 0);

        $display("[TB] reset mid-run");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("pre_reset_a2", int'(multiplier), ma[2]);
        #2 reset = 1'b1;
        #1;
        checkOutput("midrst_busy", int'(busy), 0);
        checkOutput("midrst_mult", int'(multiplier), 0);
        checkOutput("midrst_mcand", int'(multiplicand), 0);
        checkOutput("midrst_mac_clr", int'(mac_clr), 0);
        checkOutput("midrst_done", int'(done), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < LEN; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end
        repeat (5) @(negedge clk);
        checkOutput("post_rst_idle", int'(busy), 0);
        applyStimulus(0);
        loadVectors('{1, 2, 3, 4}, '{1, 1, 1, 1});
        applyStimulus(0);

        repeat (4) @(negedge clk);
        checkOutput("done_count", done_count, runs);
        checkOutput("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_operand_feeder.md
Name: mac_operand_feeder

Overview:
- Upstream stage of the `mac` block in the MATRIX datapath.
- Holds two operand vectors A and B of LEN elements each, loaded through a simple write port.
- On `start`, clears the MAC accumulator, then streams one (A[i], B[i]) pair per clock onto the MAC `multiplier`/`multiplicand` inputs.
- Waits for the MAC pipeline to settle, then pulses `done`; at that point the MAC `accumulator_out` holds the dot product A·B.

Parameters:
- Nbits, 4, operand width; matches the MAC Nbits.
- LEN, 4, vector length (number of products accumulated); must be ≥1.
- AW, 2, address width for the element index; requires 2**AW ≥ LEN.
- MAC_LAT, 1, clocks from an operand pair appearing on the MAC inputs until it is reflected in `accumulator_out`.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe for operand storage.
- wr_sel  in  1  0 = write vector A, 1 = write vector B.
- wr_addr  in  AW  element index.
- wr_data  in  Nbits  element value.
- start  in  1  request a dot-product run; level sampled each clock.
- busy  out  1  high in every state except IDLE.
- mac_clr  out  1  drives the MAC reset; high for exactly one cycle per run.
- multiplier  out  Nbits  A element to the MAC.
- multiplicand  out  Nbits  B element to the MAC.
- done  out  1  one-cycle pulse: the MAC result is valid.

Behaviour:
- Reset (asynchronous, active-high), while asserted:
  - state = IDLE; index = 0.
  - All A and B entries = 0.
  - `busy`, `mac_clr`, `done`, `multiplier`, `multiplicand` = 0.
- All outputs are registered, so each output is a function of the current state and index.
- State machine (edges counted from E0, the edge at which `start` is sampled in IDLE):
  - IDLE: `start`=1 → CLEAR.
  - CLEAR: one cycle (after E0); `mac_clr`=1, operands = 0, `busy`=1; → FEED with index = 0.
  - FEED: LEN cycles (after E1 through E(LEN)).
    - `multiplier` = A[index], `multiplicand` = B[index].
    - index increments each edge.
    - After index LEN-1 → DRAIN.
  - DRAIN: MAC_LAT cycles; operands = 0; → DONE.
  - DONE: one cycle; `done`=1, `busy`=1, operands = 0; → IDLE.
- `done` is first high in the cycle after edge E(1+LEN+MAC_LAT).
  - Default parameters: E6, i.e. 7 clocks of `busy` in total.
- Operands are forced to 0 in every state except FEED, so the free-running MAC adds 0 when it is not being fed.
- `mac_clr` is 0 in every state except CLEAR.
- Write port:
  - Accepted only in IDLE with `wr_en`=1 and `wr_addr` < LEN; the addressed entry is updated at the clock edge.
  - Writes with `wr_addr` ≥ LEN are ignored.
  - Writes while `busy`=1 are ignored; stored data is unchanged.
- `start` while `busy`=1 is ignored, including during the DONE cycle; no queuing.
- `start` and `wr_en` together in IDLE: the write commits at E0 and the run uses the new value.
- Back-to-back runs: `start` held high continuously gives IDLE for one cycle, then a new CLEAR.
- Reset mid-run: immediately IDLE, all outputs 0; no `done` is produced; the partial MAC result is meaningless.
- Arithmetic:
  - The feeder does no arithmetic and has no width growth.
  - Results wrap modulo 2**(2*Nbits) in the MAC (Nbits=4: worst case 4·15·15 = 900 wraps to 132).

Test Plan:
- Reset then idle: hold `reset` 10 cycles → all outputs 0 and `busy`=0; release, no `start` for 20 cycles → outputs remain 0 and MAC `accumulator_out` stays 0.
- Basic dot product (Nbits=4, LEN=4): load A=[1,2,3,4], B=[1,1,1,1], pulse `start` → `mac_clr` high one cycle, `multiplier` sequence 1,2,3,4 on consecutive cycles, `done` 1 cycle at E6, `accumulator_out`=10 while `done`=1 and thereafter.
- Overflow wrap: A=B=[15,15,15,15], `start` → `done` with `accumulator_out`=132; second run with A=[2,2,2,2], B=[2,2,2,2] → 16, proving `mac_clr` clears the previous result.
- Writes during busy and out of range: start with A=[1,2,3,4], B=[1,1,1,1]; during FEED write A[0]=9 → result still 10. In IDLE write A[3]=7 with `wr_addr`=3 → next run gives 13; a write with AW=3, `wr_addr`=5 is ignored.
- Same-cycle write and start: in IDLE assert `wr_en` (A[0]=5) together with `start` → run uses A[0]=5, result 14 for A=[5,2,3,4], B=[1,1,1,1]; a `start` pulse during FEED is ignored (exactly one `done`).
- Reset mid-run: assert `reset` during FEED index 2 → outputs 0 asynchronously with no `done`; after release, reload and start → correct result 10 and a single `done`.
